// File: rtl/load_store_unit.sv
// Per-thread load/store engine: one valid/ready memory transaction per
// LDR/STR, result held until the scheduler reaches UPDATE.
module load_store_unit #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read,
  input  logic                 decoded_mem_write,
  input  logic [DATA_BITS-1:0] rs_data,
  input  logic [DATA_BITS-1:0] rt_data,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [2:0] CS_REQUEST = 3'b011;
  localparam logic [2:0] CS_UPDATE  = 3'b110;

  state_t                 r_state;
  logic                   r_is_read;
  logic                   r_rvalid;
  logic                   r_wvalid;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [DATA_BITS-1:0]   r_wdata;
  logic [DATA_BITS-1:0]   r_lsu_out;
  logic                   w_start;

  assign w_start = enable
                && (core_state == CS_REQUEST)
                && (decoded_mem_read | decoded_mem_write);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_is_read <= 1'b0;
      r_rvalid  <= 1'b0;
      r_wvalid  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_lsu_out <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // Operands are captured here so later rs/rt changes are invisible.
          if (w_start) begin
            r_is_read <= decoded_mem_read;
            r_addr    <= rs_data[ADDR_BITS-1:0];
            r_wdata   <= rt_data;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          r_rvalid <= r_is_read;
          r_wvalid <= !r_is_read;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_is_read) begin
            if (mem_read_ready) begin
              r_lsu_out <= mem_read_data;
              r_rvalid  <= 1'b0;
              r_state   <= S_DONE;
            end
          end else if (mem_write_ready) begin
            r_wvalid <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (core_state == CS_UPDATE)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_read_valid    = r_rvalid;
  assign mem_read_address  = r_addr;
  assign mem_write_valid   = r_wvalid;
  assign mem_write_address = r_addr;
  assign mem_write_data    = r_wdata;
  assign lsu_state         = r_state;
  assign lsu_out           = r_lsu_out;

endmodule
